sap1_operand_registers: RTL

- Bus-side receiver for the SAP-1 arithmetic path.
- Captures operands from the shared 8-bit W bus into the accumulator (A) and B registers.
- Presents A and B continuously to the adder/subtractor, and drives A back onto the bus when enabled.
- With the optional feature compiled in, latches carry/zero flags from the adder result for later conditional jumps.

---
 rtl/sap1_operand_registers.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sap1_operand_registers.sv
// ---------------------------------------------------------------------------
// sap1_operand_registers
//
// The SAP-1 arithmetic path takes its operands from the W bus through this
// block. It holds the accumulator (A) and the B register, and it always shows
// both to the adder/subtractor. When E_A is high it also drives A back onto
// the bus.
//
// Optional feature macro: SAP1_OPERAND_FLAGS_EN
//   defined   : a {carry, zero} flag register captures the adder result when
//               L_F is high.
//   undefined : no flag flops are built, flags_output is tied to 2'b00, and
//               L_F / sum_input / carry_input are ignored.
//
// CLR is a synchronous, active-high reset that overrides every load strobe.
// ---------------------------------------------------------------------------
module sap1_operand_registers #(
  parameter int unsigned WIDTH      = 8,
  parameter logic [1:0]  FLAG_RESET = 2'b00
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] bus_input,
  input  logic             L_A,
  input  logic             E_A,
  input  logic             L_B,
  output logic [WIDTH-1:0] bus_output,
  output logic [WIDTH-1:0] a_output,
  output logic [WIDTH-1:0] b_output,
  input  logic [WIDTH-1:0] sum_input,
  input  logic             carry_input,
  input  logic             L_F,
  output logic [1:0]       flags_output,
  output logic             conflict
);

  // Operand registers and their next-state values.
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] b_d;

  // Registered strobe for the self-transfer case (L_A and E_A both high).
  logic             conflict_q;
  logic             conflict_d;
  logic             self_xfer_s;

  assign self_xfer_s = L_A & E_A;

  // Next-state logic for A, B and the conflict strobe.
  // During a self-transfer A keeps its own value. The bus would only carry A
  // back anyway, and taking the value from a_q avoids a bus round trip.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    conflict_d = 1'b0;
    if (CLR) begin
      a_d        = {WIDTH{1'b0}};
      b_d        = {WIDTH{1'b0}};
      conflict_d = 1'b0;
    end else begin
      if (self_xfer_s) begin
        a_d = a_q;
      end else if (L_A) begin
        a_d = bus_input;
      end else begin
        a_d = a_q;
      end

      if (L_B) begin
        b_d = bus_input;
      end else begin
        b_d = b_q;
      end

      conflict_d = self_xfer_s;
    end
  end

  // Operand and conflict state update on the rising clock edge.
  always_ff @(posedge CLK) begin
    a_q        <= a_d;
    b_q        <= b_d;
    conflict_q <= conflict_d;
  end

  // The adder inputs are always driven straight from the registers.
  assign a_output = a_q;
  assign b_output = b_q;
  assign conflict = conflict_q;

  // The bus driver is combinational, so it releases in the same delta that
  // E_A falls. A is defined after the first reset, so it never drives X.
  assign bus_output = E_A ? a_q : {WIDTH{1'bz}};

`ifdef SAP1_OPERAND_FLAGS_EN
  // Flag register: bit 1 is carry, bit 0 is zero.
  logic [1:0] flags_q;
  logic [1:0] flags_d;
  logic       zero_s;

  assign zero_s = (sum_input == {WIDTH{1'b0}});

  // Next-state logic for the flags. In subtract mode carry_input means
  // "no borrow", and it is stored exactly as received.
  always_comb begin
    flags_d = flags_q;
    if (CLR) begin
      flags_d = FLAG_RESET;
    end else if (L_F) begin
      flags_d = {carry_input, zero_s};
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag state update on the rising clock edge.
  always_ff @(posedge CLK) begin
    flags_q <= flags_d;
  end

  assign flags_output = flags_q;
`else
  // With the flag register left out, the flag inputs go nowhere. They are
  // folded into one sink signal so that they are consumed.
  logic unused_flag_inputs_s;

  assign unused_flag_inputs_s = ^{L_F, carry_input, sum_input, FLAG_RESET};
  assign flags_output         = 2'b00;
`endif

endmodule
